// File: rtl/period_capture_pkg.sv
// Shared definitions for the period_capture block: FSM state encoding and
// active-edge select constants.
package period_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEASURE   = 2'd1,
    ST_SATURATED = 2'd2
  } state_t;

  localparam logic SLOPE_FALL = 1'b0;
  localparam logic SLOPE_RISE = 1'b1;

endpackage

// File: rtl/period_capture_edge_select_detect.sv
// Active-edge detector with slope select. Define PERIOD_CAPTURE_SYNC_EN to put
// a 2-flop synchronizer in front of the edge detector for asynchronous inputs.
module edge_select_detect
  import period_capture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_slope,
  input  logic i_sig_in,
  output logic o_act_edge
);

  logic w_sig;
  logic w_rise;
  logic w_fall;
  logic r_sig_prev;

`ifdef PERIOD_CAPTURE_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[0], i_sig_in};
  end

  assign w_sig = r_sync[1];
`else
  assign w_sig = i_sig_in;
`endif

  // Tracks the input every cycle, even while disabled, so re-enabling never
  // sees a stale level and reports a phantom edge.
  always_ff @(posedge clk) begin
    if (!reset) r_sig_prev <= 1'b0;
    else        r_sig_prev <= w_sig;
  end

  assign w_rise = w_sig & ~r_sig_prev;
  assign w_fall = ~w_sig & r_sig_prev;

  always_comb begin
    case (i_slope)
      SLOPE_RISE: o_act_edge = w_rise;
      SLOPE_FALL: o_act_edge = w_fall;
      default:    o_act_edge = 1'b0;
    endcase
  end

endmodule

// File: rtl/period_capture.sv
// Edge-to-edge period meter with valid/ready result delivery and saturation.
// Optional input synchronizer enabled by defining PERIOD_CAPTURE_SYNC_EN.
module period_capture
  import period_capture_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             slope,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             overflow,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] w_cap_value;
  logic             r_slope_q;
  logic             r_valid;
  logic             r_overflow;
  logic             r_overrun;
  logic             w_act_edge;
  logic             w_abort;
  logic             w_capture;
  logic             w_cap_ovf;

  edge_select_detect u_edge (
    .clk        (clk),
    .reset      (reset),
    .i_slope    (slope),
    .i_sig_in   (sig_in),
    .o_act_edge (w_act_edge)
  );

  // A slope change mid-measurement invalidates the interval, same as disable.
  assign w_abort = !enable || ((r_state != ST_IDLE) && (slope != r_slope_q));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:      if (w_act_edge) w_state_next = ST_MEASURE;
        ST_MEASURE:   if (!w_act_edge && (r_cnt == CNT_MAX)) w_state_next = ST_SATURATED;
        ST_SATURATED: if (w_act_edge) w_state_next = ST_MEASURE;
        default:      w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture   = 1'b0;
    w_cap_value = r_cnt;
    w_cap_ovf   = 1'b0;
    w_cnt_next  = r_cnt;
    if (w_abort) begin
      w_cnt_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: w_cnt_next = w_act_edge ? CNT_ONE : '0;
        ST_MEASURE: begin
          if (w_act_edge) begin
            w_capture   = 1'b1;
            w_cap_value = r_cnt;
            w_cap_ovf   = (r_cnt == CNT_MAX);
            w_cnt_next  = CNT_ONE;
          end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_ONE;
          end
        end
        ST_SATURATED: begin
          if (w_act_edge) begin
            w_capture   = 1'b1;
            w_cap_value = CNT_MAX;
            w_cap_ovf   = 1'b1;
            w_cnt_next  = CNT_ONE;
          end else begin
            w_cnt_next = CNT_MAX;
          end
        end
        default: w_cnt_next = '0;
      endcase
    end
  end

  // A new capture always wins over consumption; it only flags overrun when the
  // pending result was not taken in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_slope_q  <= 1'b0;
      r_period   <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_slope_q <= slope;
      if (w_capture) begin
        r_period   <= w_cap_value;
        r_overflow <= w_cap_ovf;
        r_valid    <= 1'b1;
        if (r_valid && !period_ready) r_overrun <= 1'b1;
      end else if (r_valid && period_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign overflow     = r_overflow;
  assign overrun      = r_overrun;

endmodule
